// File: rtl/uart_core.sv
// UART core: 16x-oversampled TX/RX with valid/ready byte handshakes.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_core #(
  parameter int CLK_DIV    = 326,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_e;

  localparam logic [2:0] LAST  = 3'(DATA_W - 1);
  localparam logic       SLAST = 1'(STOP_BITS - 1);
  localparam logic       PODD  = 1'(PARITY_ODD);

  logic [15:0] div_q;
  logic        tick;
  logic        en_q;

  assign tick = (div_q == 16'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      en_q  <= 1'b0;
    end else begin
      div_q <= tick ? '0 : div_q + 16'd1;
      en_q  <= 1'b1;
    end
  end

  st_e               ts_q, ts_d;
  logic [3:0]        tcnt_q, tcnt_d;
  logic [2:0]        tbit_q, tbit_d;
  logic [DATA_W-1:0] tsh_q, tsh_d;
  logic              tstop_q, tstop_d;
  logic              tpar_q, tpar_d;
  logic              tend;

  assign tend     = tick && (tcnt_q == 4'hF);
  assign tx_ready = en_q && (ts_q == S_IDLE);
  assign tx_busy  = (ts_q != S_IDLE);

  always_comb begin
    ts_d    = ts_q;
    tcnt_d  = tcnt_q;
    tbit_d  = tbit_q;
    tsh_d   = tsh_q;
    tstop_d = tstop_q;
    tpar_d  = tpar_q;
    if (tick) tcnt_d = tcnt_q + 4'd1;
    unique case (ts_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (tx_valid && tx_ready) begin
          ts_d   = S_START;
          tsh_d  = tx_data;
          tpar_d = (^tx_data) ^ PODD;
        end
      end
      S_START: if (tend) begin
        ts_d   = S_DATA;
        tbit_d = '0;
      end
      S_DATA: if (tend) begin
        tsh_d  = tsh_q >> 1;
        tbit_d = tbit_q + 3'd1;
        if (tbit_q == LAST) begin
`ifdef UART_PARITY_EN
          ts_d = S_PAR;
`else
          ts_d = S_STOP;
`endif
          tstop_d = 1'b0;
        end
      end
      S_PAR: if (tend) begin
        ts_d    = S_STOP;
        tstop_d = 1'b0;
      end
      S_STOP: if (tend) begin
        if (tstop_q == SLAST) ts_d = S_IDLE;
        else tstop_d = 1'b1;
      end
      default: ts_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (ts_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = tsh_q[0];
`ifdef UART_PARITY_EN
      S_PAR:   tx = tpar_q;
`endif
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_q    <= S_IDLE;
      tcnt_q  <= '0;
      tbit_q  <= '0;
      tsh_q   <= '0;
      tstop_q <= 1'b0;
      tpar_q  <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      tcnt_q  <= tcnt_d;
      tbit_q  <= tbit_d;
      tsh_q   <= tsh_d;
      tstop_q <= tstop_d;
      tpar_q  <= tpar_d;
    end
  end

  logic              s1_q, s2_q;
  st_e               rs_q, rs_d;
  logic [3:0]        rcnt_q, rcnt_d;
  logic [2:0]        rbit_q, rbit_d;
  logic [DATA_W-1:0] rsh_q, rsh_d;
  logic              rstop_q, rstop_d;
  logic              rperr_q, rperr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;
  logic              ovr_q, ovr_d;
  logic              rgood, rend, rmid;

  assign rend = tick && (rcnt_q == 4'hF);
  assign rmid = tick && (rcnt_q == 4'h7);

  always_comb begin
    rs_d     = rs_q;
    rcnt_d   = rcnt_q;
    rbit_d   = rbit_q;
    rsh_d    = rsh_q;
    rstop_d  = rstop_q;
    rperr_d  = rperr_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    ferr_d   = 1'b0;
    perr_d   = 1'b0;
    ovr_d    = 1'b0;
    rgood    = 1'b0;
    if (tick) rcnt_d = rcnt_q + 4'd1;
    if (rvalid_q && rx_ready) rvalid_d = 1'b0;
    unique case (rs_q)
      S_IDLE: begin
        rcnt_d = '0;
        if (!s2_q) rs_d = S_START;
      end
      // half a bit in: confirm the start bit before committing
      S_START: if (rmid) begin
        rcnt_d = '0;
        rbit_d = '0;
        rs_d   = s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rend) begin
        rsh_d  = {s2_q, rsh_q[DATA_W-1:1]};
        rbit_d = rbit_q + 3'd1;
        if (rbit_q == LAST) begin
`ifdef UART_PARITY_EN
          rs_d = S_PAR;
`else
          rs_d = S_STOP;
`endif
          rstop_d = 1'b0;
          rperr_d = 1'b0;
        end
      end
      S_PAR: if (rend) begin
        rperr_d = s2_q ^ (^rsh_q) ^ PODD;
        rs_d    = S_STOP;
        rstop_d = 1'b0;
      end
      S_STOP: if (rend) begin
        if (!s2_q) begin
          ferr_d = 1'b1;
          rs_d   = S_IDLE;
        end else if (rstop_q == SLAST) begin
          rs_d = S_IDLE;
          if (rperr_q) perr_d = 1'b1;
          else rgood = 1'b1;
        end else begin
          rstop_d = 1'b1;
        end
      end
      default: rs_d = S_IDLE;
    endcase
    if (rgood) begin
      if (rvalid_q && !rx_ready) begin
        ovr_d = 1'b1;
      end else begin
        rdata_d  = rsh_q;
        rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      rs_q     <= S_IDLE;
      rcnt_q   <= '0;
      rbit_q   <= '0;
      rsh_q    <= '0;
      rstop_q  <= 1'b0;
      rperr_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      s1_q     <= rx;
      s2_q     <= s1_q;
      rs_q     <= rs_d;
      rcnt_q   <= rcnt_d;
      rbit_q   <= rbit_d;
      rsh_q    <= rsh_d;
      rstop_q  <= rstop_d;
      rperr_q  <= rperr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      ovr_q    <= ovr_d;
    end
  end

  assign rx_data     = rdata_q;
  assign rx_valid    = rvalid_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;
`ifdef UART_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
  logic unused_par;
  assign unused_par  = perr_q ^ tpar_q;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: randomized loopback and injected RX frames
// checked against a frame-level model (CLK_DIV=4, bit = 64 clk).
module tb_uart_core;

  localparam int BIT = 64;
`ifdef UART_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif
  localparam logic PODD = 1'b0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_ready, tx, tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err, parity_err, overrun_err;
  logic       loop = 1'b1;
  logic       rx_drv = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_n = 0;
  int pe_n = 0;
  int ov_n = 0;

  always #5 clk = ~clk;

  assign rx = loop ? tx : rx_drv;

  uart_core #(
    .CLK_DIV(4), .DATA_W(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err),
    .overrun_err(overrun_err)
  );

  always @(posedge clk) begin
    if (rst) begin
      if (frame_err) fe_n = fe_n + 1;
      if (parity_err) pe_n = pe_n + 1;
      if (overrun_err) ov_n = ov_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line image of one frame, bit 0 first on the wire.
  function automatic logic [15:0] frame(input logic [7:0] d,
                                        input logic fpar,
                                        input logic bstop);
    logic [15:0] w;
    w = 16'(d) << 1;
`ifdef UART_PARITY_EN
    w[9]  = (^d) ^ PODD ^ fpar;
    w[10] = ~bstop;
`else
    w[9]  = ~bstop ^ (fpar & 1'b0);
`endif
    return w;
  endfunction

  task automatic drive_frame(input logic [15:0] w, input bit short_stop);
    int n;
    @(negedge clk);
    for (int i = 0; i < FL; i++) begin
      rx_drv = w[i];
      n = (short_stop && i == FL - 1) ? 44 : BIT;
      repeat (n) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic send_tx(input logic [7:0] d);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_ready) break;
    end
    chk("tx_ready", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    chk("tx_busy", 32'(tx_busy), 32'd1);
  endtask

  task automatic wait_tx_low(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (tx === 1'b0) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) chk("tx_start_timeout", 32'd0, 32'd1);
  endtask

  task automatic capture_tx(output logic [15:0] w);
    bit seen;
    w = '0;
    wait_tx_low(seen);
    if (seen) begin
      repeat (BIT / 2) @(posedge clk);
      #1 w[0] = tx;
      for (int i = 1; i < FL; i++) begin
        repeat (BIT) @(posedge clk);
        #1 w[i] = tx;
      end
    end
  endtask

  task automatic wait_rxv();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (rx_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) chk("rxv_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    chk("rxv_clear", 32'(rx_valid), 32'd0);
  endtask

  task automatic loop_byte(input logic [7:0] d);
    logic [15:0] w;
    int e0;
    e0 = fe_n + pe_n + ov_n;
    loop = 1'b1;
    send_tx(d);
    capture_tx(w);
    chk("tx_line", 32'(w), 32'(frame(d, 1'b0, 1'b0)));
    wait_rxv();
    chk("rx_data", 32'(rx_data), 32'(d));
    repeat (4) @(posedge clk);
    #1 chk("no_err", 32'(fe_n + pe_n + ov_n), 32'(e0));
    consume();
  endtask

  initial begin
    int e0;
    bit seen;
    logic [7:0] d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_rxv", 32'(rx_valid), 32'd0);
    chk("rst_rxd", 32'(rx_data), 32'd0);
    chk("rst_err", 32'({frame_err, parity_err, overrun_err}), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1 chk("ready_pre", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #1 chk("ready_rise", 32'(tx_ready), 32'd1);

    loop_byte(8'hA5);
    for (int i = 0; i < 4; i++) loop_byte(8'($urandom_range(0, 255)));

    loop = 1'b0;
    e0 = fe_n + pe_n + ov_n;
    @(negedge clk) rx_drv = 1'b0;
    repeat (20) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(posedge clk);
    #1 chk("glitch_rxv", 32'(rx_valid), 32'd0);
    chk("glitch_err", 32'(fe_n + pe_n + ov_n), 32'(e0));
    drive_frame(frame(8'h3C, 1'b0, 1'b0), 1'b0);
    wait_rxv();
    chk("post_glitch_rxd", 32'(rx_data), 32'h3C);
    consume();

    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom_range(0, 255));
      drive_frame(frame(d, 1'b0, 1'b0), 1'b0);
      wait_rxv();
      chk("rand_rxd", 32'(rx_data), 32'(d));
      consume();
    end

    e0 = fe_n;
    drive_frame(frame(8'h3C, 1'b0, 1'b1), 1'b1);
    repeat (150) @(posedge clk);
    #1 chk("frame_err", 32'(fe_n), 32'(e0 + 1));
    chk("ferr_rxv", 32'(rx_valid), 32'd0);

    e0 = ov_n;
    drive_frame(frame(8'h11, 1'b0, 1'b0), 1'b0);
    drive_frame(frame(8'h22, 1'b0, 1'b0), 1'b0);
    repeat (20) @(posedge clk);
    #1 chk("ovr_rxv", 32'(rx_valid), 32'd1);
    chk("ovr_rxd", 32'(rx_data), 32'h11);
    chk("ovr_cnt", 32'(ov_n), 32'(e0 + 1));
    consume();

`ifdef UART_PARITY_EN
    loop_byte(8'h07);
    loop = 1'b0;
    e0 = pe_n;
    drive_frame(frame(8'h07, 1'b1, 1'b0), 1'b0);
    repeat (20) @(posedge clk);
    #1 chk("parity_err", 32'(pe_n), 32'(e0 + 1));
    chk("perr_rxv", 32'(rx_valid), 32'd0);
`endif

    loop = 1'b1;
    send_tx(8'hC3);
    wait_tx_low(seen);
    repeat (BIT / 2 + BIT * 4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_ready", 32'(tx_ready), 32'd0);
    chk("mid_rst_rxd", 32'(rx_data), 32'd0);
    @(negedge clk) rst = 1'b1;
    #1 chk("rel_ready_pre", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #1 chk("rel_ready", 32'(tx_ready), 32'd1);
    chk("rel_rxv", 32'(rx_valid), 32'd0);
    loop_byte(8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
